// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle for bin2bcd_seq.
//   master: drives in_valid/in_bin, receives in_ready and the result outputs
//   slave : the converter side
// Signals:
//   in_valid  - in_bin is valid this cycle
//   in_ready  - converter can accept
//   in_bin    - unsigned value to convert (BIN_W bits)
//   out_valid - one-cycle pulse: new result on out_*
//   out_bcd   - 8 packed BCD digits, digit 0 in bits [3:0]
//   out_blank - bit i set: display digit i should be blanked
//   out_ovf   - last accepted value exceeded 99,999,999
interface bin2bcd_seq_if #(
    parameter int unsigned BIN_W = 27
) ();
    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] in_bin;
    logic             out_valid;
    logic [31:0]      out_bcd;
    logic [7:0]       out_blank;
    logic             out_ovf;

    modport master (
        output in_valid, in_bin,
        input  in_ready, out_valid, out_bcd, out_blank, out_ovf
    );

    modport slave (
        input  in_valid, in_bin,
        output in_ready, out_valid, out_bcd, out_blank, out_ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the 8-digit seven-segment driver with packed BCD digits, a
// leading-zero blank mask and an overflow flag. Results hold between pulses.
// Ports:
//   clk - clock
//   rst - synchronous, active-high reset
//   bus - bin2bcd_seq_if.slave (valid/ready input, registered result outputs)
module bin2bcd_seq #(
    parameter int unsigned BIN_W = 27,
    parameter int unsigned NDIG  = 8
) (
    input  logic           clk,
    input  logic           rst,
    bin2bcd_seq_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * NDIG;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [26:0] MAX_DEC = 27'd99_999_999;

    // S_FINISH is the cycle after the last shift, where the final mask is
    // built from the settled accumulator; S_DONE is the out_valid cycle.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [BIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic [BCD_W-1:0]   out_bcd_q;
    logic [NDIG-1:0]    out_blank_q;
    logic               out_ovf_q;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   acc_d;
    logic [BIN_W-1:0]   bin_d;
    logic [NDIG-1:0]    blank_mask;
    logic               all_zero;
    logic [26:0]        bin_ext;

    assign bin_ext = 27'(bus.in_bin);

    // Add-3 correction on every nibble in parallel, no inter-nibble carry,
    // followed by a one-bit left shift of {bcd, bin}.
    always_comb begin
        adj = acc_q;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
    end

    // Bit i (i >= 1) set when digits i..NDIG-1 are all zero; bit 0 never set.
    always_comb begin
        blank_mask = '0;
        all_zero   = 1'b1;
        for (int unsigned k = 0; k < NDIG - 1; k++) begin
            all_zero = all_zero && (acc_q[4*(NDIG-1-k) +: 4] == 4'd0);
            blank_mask[NDIG-1-k] = all_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_blank_q <= NDIG'(8'hFE);
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        bin_q   <= bus.in_bin;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(BIN_W);
                        ovf_q   <= (bin_ext > MAX_DEC);
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc_q <= acc_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    out_bcd_q   <= ovf_q ? {NDIG{4'h9}} : acc_q;
                    out_blank_q <= ovf_q ? '0 : blank_mask;
                    out_ovf_q   <= ovf_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_blank = out_blank_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq: hand-computed expected digits, masks,
// overflow flags, latency and handshake timing.
module tb_bin2bcd_seq;
    logic clk;
    logic rst;

    int errors;
    int checks;
    logic [31:0] prev_bcd;

    bin2bcd_seq_if #(.BIN_W(27)) bus ();

    bin2bcd_seq #(.BIN_W(27), .NDIG(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [26:0] v, input logic [31:0] ebcd,
                           input logic [7:0] eblank, input logic eovf, input string tag);
        int  n;
        bit  seen;
        bit  ready_bad;
        bit  hold_bad;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        check({tag, "_ready_before"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_bin   = v;
        step();
        bus.in_valid = 1'b0;
        bus.in_bin   = 27'h5A5A5A5;
        ready_bad = bus.in_ready;
        hold_bad  = (bus.out_bcd !== prev_bcd) || bus.out_valid;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (bus.in_ready) ready_bad = 1'b1;
            if (bus.out_valid) seen = 1'b1;
            else if (bus.out_bcd !== prev_bcd) hold_bad = 1'b1;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'd28);
        check({tag, "_ready_low"}, 64'(ready_bad), 64'd0);
        check({tag, "_hold"}, 64'(hold_bad), 64'd0);
        check({tag, "_bcd"}, 64'(bus.out_bcd), 64'(ebcd));
        check({tag, "_blank"}, 64'(bus.out_blank), 64'(eblank));
        check({tag, "_ovf"}, 64'(bus.out_ovf), 64'(eovf));
        step();
        check({tag, "_pulse_width"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_ready_after"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_bcd_held"}, 64'(bus.out_bcd), 64'(ebcd));
        prev_bcd = ebcd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nacc;
        int npulse;
        int acc_edge[2];
        int pulse_edge[2];
        logic [31:0] pulse_bcd[2];
        bit accepting;
        int spurious;

        errors   = 0;
        checks   = 0;
        prev_bcd = '0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bin   = 27'd5;
        step();
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_ready", 64'(bus.in_ready), 64'd1);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_bcd", 64'(bus.out_bcd), 64'd0);
        check("rst_blank", 64'(bus.out_blank), 64'hFE);
        check("rst_ovf", 64'(bus.out_ovf), 64'd0);

        convert(27'd0,          32'h00000000, 8'hFE, 1'b0, "zero");
        convert(27'd12_345_678, 32'h12345678, 8'h00, 1'b0, "n12345678");
        convert(27'd99_999_999, 32'h99999999, 8'h00, 1'b0, "max_dec");
        convert(27'd100_000_000, 32'h99999999, 8'h00, 1'b1, "ovf_1e8");
        convert(27'h7FFFFFF,    32'h99999999, 8'h00, 1'b1, "ovf_all1");
        convert(27'd305,        32'h00000305, 8'hF8, 1'b0, "n305");
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.out_bcd !== 32'h00000305 || bus.out_blank !== 8'hF8) spurious++;
        end
        check("idle_hold", 64'(spurious), 64'd0);
        convert(27'd7,          32'h00000007, 8'hFE, 1'b0, "n7");

        // in_valid held high across two handshakes
        nacc = 0;
        npulse = 0;
        bus.in_valid = 1'b1;
        bus.in_bin   = 27'd42;
        for (int e = 1; e <= 80; e++) begin
            accepting = bus.in_valid && bus.in_ready;
            step();
            if (accepting) begin
                if (nacc < 2) acc_edge[nacc] = e;
                nacc++;
                if (nacc == 1) bus.in_bin = 27'd43;
                if (nacc >= 2) bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                if (npulse < 2) begin
                    pulse_edge[npulse] = e;
                    pulse_bcd[npulse]  = bus.out_bcd;
                end
                npulse++;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", 64'(nacc), 64'd2);
        check("b2b_pulses", 64'(npulse), 64'd2);
        if (nacc >= 2)
            check("b2b_accept_gap", 64'(acc_edge[1] - acc_edge[0]), 64'd30);
        if (npulse >= 2) begin
            check("b2b_pulse_gap", 64'(pulse_edge[1] - pulse_edge[0]), 64'd30);
            check("b2b_bcd0", 64'(pulse_bcd[0]), 64'h42);
            check("b2b_bcd1", 64'(pulse_bcd[1]), 64'h43);
        end
        check("b2b_blank", 64'(bus.out_blank), 64'hFC);
        prev_bcd = 32'h00000043;

        // reset in the middle of a conversion
        while (!bus.in_ready) step();
        bus.in_valid = 1'b1;
        bus.in_bin   = 27'd12_345_678;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_ready", 64'(bus.in_ready), 64'd1);
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_bcd", 64'(bus.out_bcd), 64'd0);
        check("abort_blank", 64'(bus.out_blank), 64'hFE);
        check("abort_ovf", 64'(bus.out_ovf), 64'd0);
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.out_valid) spurious++;
        end
        check("abort_no_pulse", 64'(spurious), 64'd0);
        prev_bcd = '0;
        convert(27'd9, 32'h00000009, 8'hFE, 1'b0, "n9");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
